// File: rtl/inst_mem_loader_pkg.sv
// Shared constants for the instruction-memory boot loader and the memory write port.
// The optional checksum stage is enabled with INST_MEM_LOADER_CHECKSUM_EN (see inst_mem_loader.sv).
package inst_mem_loader_pkg;

  localparam logic [3:0] WIDTH_BYTE = 4'd1;
  localparam logic [3:0] WIDTH_HALF = 4'd2;
  localparam logic [3:0] WIDTH_WORD = 4'd4;

  localparam int HDR_BYTES = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_HDR_ADDR  = 3'd0;
  localparam state_t ST_HDR_LEN   = 3'd1;
  localparam state_t ST_PAYLOAD   = 3'd2;
  localparam state_t ST_TAIL_HALF = 3'd3;
  localparam state_t ST_TAIL_BYTE = 3'd4;
  localparam state_t ST_CHECKSUM  = 3'd5;
  localparam state_t ST_DONE      = 3'd6;
  localparam state_t ST_ERROR     = 3'd7;

  // Little-endian lane insert, shared by the header capture and the payload packer.
  function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  value);
    logic [31:0] result;
    result = word;
    case (lane)
      2'd0:    result[7:0]   = value;
      2'd1:    result[15:8]  = value;
      2'd2:    result[23:16] = value;
      default: result[31:24] = value;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/inst_mem_loader_assembler.sv
// Byte-to-word packer: collects up to three bytes and presents the completed word
// combinationally on the push that supplies the fourth byte.
module inst_mem_loader_assembler
  import inst_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  in_byte,
  output logic [31:0] word_next,
  output logic        word_done,
  output logic [1:0]  fill_count,
  output logic [23:0] held_bytes
);

  logic [23:0] hold_q, hold_d;
  logic [1:0]  fill_q, fill_d;

  always_comb begin
    word_next = insert_byte({8'h00, hold_q}, fill_q, in_byte);
    word_done = push && (fill_q == 2'd3);
    hold_d    = hold_q;
    fill_d    = fill_q;
    if (clear) begin
      hold_d = '0;
      fill_d = '0;
    end else if (push) begin
      fill_d = fill_q + 2'd1;
      hold_d = word_done ? 24'h0 : word_next[23:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      fill_q <= '0;
    end else begin
      hold_q <= hold_d;
      fill_q <= fill_d;
    end
  end

  assign fill_count = fill_q;
  assign held_bytes = hold_q;

endmodule

// File: rtl/inst_mem_loader.sv
// Boot-time loader: parses an address/length header and streams the program image into
// instruction memory. Define INST_MEM_LOADER_CHECKSUM_EN to require a trailing sum byte.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int MEMORY_DEPTH_IN_BYTE = 16384,
  parameter int ADDR_WIDTH           = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_write_enable,
  output logic [3:0]            mem_write_width,
  output logic [31:0]           mem_write_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

`ifdef INST_MEM_LOADER_CHECKSUM_EN
  localparam state_t ST_AFTER_PAYLOAD = ST_CHECKSUM;
`else
  localparam state_t ST_AFTER_PAYLOAD = ST_DONE;
`endif

  state_t                state_q, state_d;
  logic [2:0]            hdr_cnt_q, hdr_cnt_d;
  logic [31:0]           base_q, base_d;
  logic [31:0]           len_q, len_d;
  logic [31:0]           offset_q, offset_d;
  logic [31:0]           count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [3:0]            width_q, width_d;
  logic [31:0]           data_q, data_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  hold_q, hold_d;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
`endif

  logic        accept;
  logic        asm_clear;
  logic        asm_push;
  logic [31:0] asm_word;
  logic        asm_word_done;
  logic [1:0]  asm_fill;
  logic [23:0] asm_held;
  logic [31:0] len_word;
  logic [32:0] bound;

  inst_mem_loader_assembler u_assembler (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .push       (asm_push),
    .in_byte    (in_data),
    .word_next  (asm_word),
    .word_done  (asm_word_done),
    .fill_count (asm_fill),
    .held_bytes (asm_held)
  );

  // ERROR keeps accepting so the host link never stalls; the bytes are simply dropped.
  always_comb begin
    in_ready = (state_q == ST_HDR_ADDR) || (state_q == ST_HDR_LEN) ||
               (state_q == ST_PAYLOAD)  || (state_q == ST_CHECKSUM) ||
               (state_q == ST_ERROR);
  end

  always_comb begin
    accept    = in_valid && in_ready;
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    base_d    = base_q;
    len_d     = len_q;
    offset_d  = offset_q;
    count_d   = count_q;
    addr_d    = addr_q;
    we_d      = 1'b0;
    width_d   = width_q;
    data_d    = data_q;
    asm_clear = 1'b0;
    asm_push  = 1'b0;
    len_word  = insert_byte(len_q, hdr_cnt_q[1:0], in_data);
    bound     = {1'b0, base_q} + {1'b0, len_word};
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif

    if (start && ((state_q == ST_DONE) || (state_q == ST_ERROR))) begin
      state_d   = ST_HDR_ADDR;
      hdr_cnt_d = '0;
      base_d    = '0;
      len_d     = '0;
      offset_d  = '0;
      count_d   = '0;
      asm_clear = 1'b1;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      sum_d     = '0;
`endif
    end else begin
      case (state_q)
        ST_HDR_ADDR: begin
          if (accept) begin
            base_d    = insert_byte(base_q, hdr_cnt_q[1:0], in_data);
            hdr_cnt_d = hdr_cnt_q + 3'd1;
            if (hdr_cnt_q == 3'd3) state_d = ST_HDR_LEN;
          end
        end
        ST_HDR_LEN: begin
          if (accept) begin
            len_d     = len_word;
            hdr_cnt_d = hdr_cnt_q + 3'd1;
            // The sum is taken one bit wider so a wrapping base cannot slip past the check.
            if (hdr_cnt_q == 3'(HDR_BYTES - 1)) begin
              if (len_word == 32'd0) begin
                state_d = ST_AFTER_PAYLOAD;
              end else if (bound > 33'(MEMORY_DEPTH_IN_BYTE)) begin
                state_d = ST_ERROR;
              end else begin
                state_d   = ST_PAYLOAD;
                offset_d  = '0;
                count_d   = '0;
                asm_clear = 1'b1;
              end
            end
          end
        end
        ST_PAYLOAD: begin
          if (accept) begin
            asm_push = 1'b1;
            count_d  = count_q + 32'd1;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
            sum_d    = sum_q + in_data;
`endif
            if (asm_word_done) begin
              we_d     = 1'b1;
              width_d  = WIDTH_WORD;
              addr_d   = ADDR_WIDTH'(base_q + offset_q);
              data_d   = asm_word;
              offset_d = offset_q + 32'd4;
            end
            if (count_q == len_q - 32'd1) begin
              case (len_q[1:0])
                2'd0:    state_d = ST_AFTER_PAYLOAD;
                2'd1:    state_d = ST_TAIL_BYTE;
                default: state_d = ST_TAIL_HALF;
              endcase
            end
          end
        end
        ST_TAIL_HALF: begin
          we_d    = 1'b1;
          width_d = WIDTH_HALF;
          addr_d  = ADDR_WIDTH'(base_q + offset_q);
          data_d  = {16'h0000, asm_held[15:0]};
          state_d = (asm_fill == 2'd3) ? ST_TAIL_BYTE : ST_AFTER_PAYLOAD;
        end
        ST_TAIL_BYTE: begin
          // With three leftover bytes the half write already covered lanes 0-1.
          we_d    = 1'b1;
          width_d = WIDTH_BYTE;
          addr_d  = ADDR_WIDTH'(base_q + offset_q + {30'd0, asm_fill[1], 1'b0});
          data_d  = {24'h000000, asm_fill[1] ? asm_held[23:16] : asm_held[7:0]};
          state_d = ST_AFTER_PAYLOAD;
        end
`ifdef INST_MEM_LOADER_CHECKSUM_EN
        ST_CHECKSUM: begin
          if (accept) state_d = (in_data == sum_q) ? ST_DONE : ST_ERROR;
        end
`endif
        ST_DONE:  ;
        ST_ERROR: ;
        default:  state_d = ST_HDR_ADDR;
      endcase
    end

    // done waits until the cycle after the final write has been presented.
    done_d  = (state_d == ST_DONE) && !we_d;
    error_d = (state_d == ST_ERROR);
    hold_d  = !done_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HDR_ADDR;
      hdr_cnt_q <= '0;
      base_q    <= '0;
      len_q     <= '0;
      offset_q  <= '0;
      count_q   <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      width_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      hold_q    <= 1'b1;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      base_q    <= base_d;
      len_q     <= len_d;
      offset_q  <= offset_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      width_q   <= width_d;
      data_q    <= data_d;
      done_q    <= done_d;
      error_q   <= error_d;
      hold_q    <= hold_d;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign mem_addr         = addr_q;
  assign mem_write_enable = we_q;
  assign mem_write_width  = width_q;
  assign mem_write_data   = data_q;
  assign done             = done_q;
  assign error            = error_q;
  assign cpu_hold         = hold_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: expected memory writes are queued when a stream is
// driven and popped by a write monitor as the loader produces them.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] mem_addr;
  logic        mem_write_enable;
  logic [3:0]  mem_write_width;
  logic [31:0] mem_write_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  width;
    logic [31:0] data;
  } wr_t;

  wr_t        expQ[$];
  logic [7:0] payload[$];
  int         total = 0;
  int         bad = 0;
  int         writesSeen = 0;
  int         w0;

  inst_mem_loader #(
    .MEMORY_DEPTH_IN_BYTE (16384),
    .ADDR_WIDTH           (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .mem_addr         (mem_addr),
    .mem_write_enable (mem_write_enable),
    .mem_write_width  (mem_write_width),
    .mem_write_data   (mem_write_data),
    .cpu_hold         (cpu_hold),
    .done             (done),
    .error            (error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Every write strobe must match the oldest queued expectation.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (mem_write_enable === 1'b1) begin
        writesSeen++;
        checkOutput("write_was_expected", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) begin
          w = expQ.pop_front();
          checkOutput("wr_addr", mem_addr, w.addr);
          checkOutput("wr_width", 32'(mem_write_width), 32'(w.width));
          checkOutput("wr_data", mem_write_data, w.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic sendByte(input logic [7:0] value, input bit gaps);
    bit accepted;
    int idle;
    idle = 0;
    while (gaps && idle < 4 && $urandom_range(0, 1) == 1) begin
      in_valid = 1'b0;
      @(negedge clk);
      idle++;
    end
    in_valid = 1'b1;
    in_data  = value;
    accepted = 1'b0;
    for (int k = 0; k < 40 && !accepted; k++) begin
      accepted = in_ready;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("byte_accepted", 32'(accepted), 32'd1);
  endtask

  task automatic sendHeader(input logic [31:0] base, input logic [31:0] len, input bit gaps);
    for (int i = 0; i < 4; i++) sendByte(base[i*8 +: 8], gaps);
    for (int i = 0; i < 4; i++) sendByte(len[i*8 +: 8], gaps);
  endtask

  task automatic pushExpected(input logic [31:0] base, input int len);
    wr_t w;
    int  off;
    int  r;
    off = 0;
    while (off + 4 <= len) begin
      w.addr  = base + 32'(off);
      w.width = 4'd4;
      w.data  = {payload[off+3], payload[off+2], payload[off+1], payload[off]};
      expQ.push_back(w);
      off += 4;
    end
    r = len - off;
    if (r == 1) begin
      w.addr = base + 32'(off); w.width = 4'd1; w.data = {24'h0, payload[off]};
      expQ.push_back(w);
    end else if (r >= 2) begin
      w.addr = base + 32'(off); w.width = 4'd2; w.data = {16'h0, payload[off+1], payload[off]};
      expQ.push_back(w);
      if (r == 3) begin
        w.addr = base + 32'(off + 2); w.width = 4'd1; w.data = {24'h0, payload[off+2]};
        expQ.push_back(w);
      end
    end
  endtask

  task automatic applyStimulus(input logic [31:0] base, input int len, input bit gaps);
    logic [7:0] sum;
    sum = 8'h00;
    pushExpected(base, len);
    sendHeader(base, 32'(len), gaps);
    for (int i = 0; i < len; i++) begin
      sendByte(payload[i], gaps);
      sum = sum + payload[i];
    end
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    sendByte(sum, gaps);
`endif
  endtask

  task automatic waitDone(input string tag);
    int k;
    k = 0;
    while (k < 50 && done !== 1'b1 && error !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_error"}, 32'(error), 32'd0);
    checkOutput({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    checkOutput({tag, "_queue_empty"}, 32'(expQ.size()), 32'd0);
  endtask

  task automatic pulseStart(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, "_start_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_start_error"}, 32'(error), 32'd0);
    checkOutput({tag, "_start_hold"}, 32'(cpu_hold), 32'd1);
    checkOutput({tag, "_start_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    checkOutput({tag, "_we"}, 32'(mem_write_enable), 32'd0);
    checkOutput({tag, "_width"}, 32'(mem_write_width), 32'd0);
    checkOutput({tag, "_data"}, mem_write_data, 32'd0);
    checkOutput({tag, "_addr"}, mem_addr, 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] aligned word load");
    payload = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    w0 = writesSeen;
    applyStimulus(32'h0000_0100, 8, 1'b0);
`ifndef INST_MEM_LOADER_CHECKSUM_EN
    checkOutput("A_last_write_visible", 32'(mem_write_enable), 32'd1);
    checkOutput("A_done_not_yet", 32'(done), 32'd0);
    @(negedge clk);
`endif
    waitDone("A");
    checkOutput("A_write_count", 32'(writesSeen - w0), 32'd2);

    $display("[TB] misaligned load with three-byte tail");
    pulseStart("B");
    payload = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    w0 = writesSeen;
    applyStimulus(32'h0000_0203, 7, 1'b0);
`ifndef INST_MEM_LOADER_CHECKSUM_EN
    checkOutput("B_tail1_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    checkOutput("B_tail2_ready", 32'(in_ready), 32'd0);
    checkOutput("B_tail2_we", 32'(mem_write_enable), 32'd1);
`endif
    waitDone("B");
    checkOutput("B_write_count", 32'(writesSeen - w0), 32'd3);

    $display("[TB] zero-length load");
    pulseStart("C");
    payload.delete();
    w0 = writesSeen;
    applyStimulus(32'h0000_1234, 0, 1'b0);
`ifndef INST_MEM_LOADER_CHECKSUM_EN
    checkOutput("C_done_next_cycle", 32'(done), 32'd1);
`endif
    waitDone("C");
    checkOutput("C_write_count", 32'(writesSeen - w0), 32'd0);

    $display("[TB] out-of-bounds load");
    pulseStart("D");
    w0 = writesSeen;
    sendHeader(32'h0000_3FFE, 32'd4, 1'b0);
    checkOutput("D_error", 32'(error), 32'd1);
    checkOutput("D_hold", 32'(cpu_hold), 32'd1);
    checkOutput("D_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) sendByte(8'hC0 + 8'(i), 1'b0);
    @(negedge clk);
    checkOutput("D_error_sticky", 32'(error), 32'd1);
    checkOutput("D_done_low", 32'(done), 32'd0);
    checkOutput("D_write_count", 32'(writesSeen - w0), 32'd0);
    pulseStart("D2");
    payload = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    w0 = writesSeen;
    applyStimulus(32'h0000_0010, 5, 1'b0);
    waitDone("D2");
    checkOutput("D2_write_count", 32'(writesSeen - w0), 32'd2);

    $display("[TB] gappy stream");
    pulseStart("E");
    payload.delete();
    for (int i = 0; i < 13; i++) payload.push_back(8'($urandom_range(0, 255)));
    w0 = writesSeen;
    applyStimulus(32'h0000_0040, 13, 1'b1);
    waitDone("E");
    checkOutput("E_write_count", 32'(writesSeen - w0), 32'd4);

`ifdef INST_MEM_LOADER_CHECKSUM_EN
    $display("[TB] checksum good and bad");
    pulseStart("G");
    payload = '{8'h01, 8'h02};
    pushExpected(32'h0000_0020, 2);
    sendHeader(32'h0000_0020, 32'd2, 1'b0);
    sendByte(8'h01, 1'b0);
    sendByte(8'h02, 1'b0);
    sendByte(8'h03, 1'b0);
    waitDone("G");
    pulseStart("G2");
    pushExpected(32'h0000_0020, 2);
    sendHeader(32'h0000_0020, 32'd2, 1'b0);
    sendByte(8'h01, 1'b0);
    sendByte(8'h02, 1'b0);
    sendByte(8'h04, 1'b0);
    @(negedge clk);
    checkOutput("G2_error", 32'(error), 32'd1);
    checkOutput("G2_done", 32'(done), 32'd0);
    checkOutput("G2_queue_empty", 32'(expQ.size()), 32'd0);
`endif

    $display("[TB] reset mid-payload");
    pulseStart("F");
    payload = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58,
                8'h59, 8'h5A, 8'h5B, 8'h5C};
    expQ.push_back('{addr: 32'h0000_0080, width: 4'd4, data: 32'h5453_5251});
    w0 = writesSeen;
    sendHeader(32'h0000_0080, 32'd12, 1'b0);
    for (int i = 0; i < 6; i++) sendByte(payload[i], 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkResetValues("F_reset");
    rst = 1'b0;
    @(negedge clk);
    checkOutput("F_queue_empty", 32'(expQ.size()), 32'd0);
    checkOutput("F_write_count", 32'(writesSeen - w0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
